// File: rtl/shift_sched_pkg.sv
// ---------------------------------------------------------------------------
// shift_sched_pkg
// Shared definitions for the shift/rotate scheduler: the op codes understood
// by the 1-bit step engine, the scheduler FSM states, and the requester that
// gets first priority after reset.
// ---------------------------------------------------------------------------
package shift_sched_pkg;

    // Op codes 5..7 all behave as PASS; only OP_PASS is named.
    typedef enum logic [2:0] {
        OP_ROTR = 3'd0,
        OP_ROTL = 3'd1,
        OP_SHL  = 3'd2,
        OP_SHR  = 3'd3,
        OP_ASR  = 3'd4,
        OP_PASS = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    // Requester that wins the first arbitration after reset. The grant
    // pointer resets to the requester just before it (with wrap).
    localparam int RST_GRANT = 0;

    // True for every op code that leaves the data untouched.
    function automatic logic is_pass_op(input logic [2:0] op);
        return op >= OP_PASS;
    endfunction

endpackage

// File: rtl/shift_step.sv
// ---------------------------------------------------------------------------
// shift_step
// Combinational single-bit step of a W-bit word.
//   op       : operation code (shift_sched_pkg::op_e, 5..7 = pass)
//   data_in  : current accumulator value
//   sign     : fill bit for ASR (MSB captured when the command was granted)
//   data_out : data_in moved one bit position according to op
// ---------------------------------------------------------------------------
module shift_step
    import shift_sched_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [2:0]   op,
    input  logic [W-1:0] data_in,
    input  logic         sign,
    output logic [W-1:0] data_out
);

    always_comb begin
        data_out = data_in;
        case (op)
            OP_ROTR: data_out = {data_in[0], data_in[W-1:1]};
            OP_ROTL: data_out = {data_in[W-2:0], data_in[W-1]};
            OP_SHL:  data_out = {data_in[W-2:0], 1'b0};
            OP_SHR:  data_out = {1'b0, data_in[W-1:1]};
            OP_ASR:  data_out = {sign, data_in[W-1:1]};
            default: data_out = data_in;
        endcase
    end

endmodule

// File: rtl/shift_sched.sv
// ---------------------------------------------------------------------------
// shift_sched
// Round-robin scheduler sharing one iterative shift/rotate engine between
// NREQ requesters. One command is granted at a time; the engine moves the
// accumulator one bit per cycle and the result is returned with the id of
// the requester that issued it.
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   req_valid  : per-requester command valid            [NREQ]
//   req_ready  : per-requester accept, at most one high [NREQ]
//   req_op     : 3-bit op per requester                 [3*NREQ]
//   req_data   : W-bit operand per requester            [W*NREQ]
//   req_amt    : AW-bit shift amount per requester      [AW*NREQ]
//   rsp_valid  : result valid (DONE state)
//   rsp_ready  : consumer accepts the result
//   rsp_data   : result word
//   rsp_id     : index of the requester that issued the command
//   busy       : high while a command is shifting or waiting in DONE
// ---------------------------------------------------------------------------
module shift_sched
    import shift_sched_pkg::*;
#(
    parameter  int W    = 8,
    parameter  int NREQ = 2,
    localparam int AW   = $clog2(W),
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [3*NREQ-1:0]    req_op,
    input  logic [W*NREQ-1:0]    req_data,
    input  logic [AW*NREQ-1:0]   req_amt,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [W-1:0]         rsp_data,
    output logic [IDW-1:0]       rsp_id,
    output logic                 busy
);

    localparam logic [IDW-1:0] LAST_GRANT_RST = IDW'((RST_GRANT + NREQ - 1) % NREQ);

    state_e          state;
    state_e          state_next;

    logic [IDW-1:0]  last_grant;
    logic [IDW-1:0]  grant_idx;
    logic [IDW-1:0]  cand;
    logic            grant_found;
    logic            accept;

    logic [2:0]      sel_op;
    logic [W-1:0]    sel_data;
    logic [AW-1:0]   sel_amt;
    logic            sel_shifts;

    logic [2:0]      op_q;
    logic [W-1:0]    acc;
    logic [IDW-1:0]  id_q;
    logic [AW-1:0]   cnt;
    logic            sign_q;
    logic [W-1:0]    step_out;

    // Search upward from the requester after the last winner, wrapping
    // around, so every waiting requester is served within NREQ-1 grants.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(last_grant) + k) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign accept = (state == S_IDLE) && grant_found;

    // Route the winning requester's command fields to the capture registers.
    always_comb begin
        sel_op   = '0;
        sel_data = '0;
        sel_amt  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                sel_op   = req_op[3*i +: 3];
                sel_data = req_data[W*i +: W];
                sel_amt  = req_amt[AW*i +: AW];
            end
        end
    end

    // PASS codes and zero amounts skip the engine entirely.
    assign sel_shifts = !is_pass_op(sel_op) && (sel_amt != '0);

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A response completing in DONE always returns to IDLE first, so a new
    // command can never be accepted in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (grant_found) begin
                    state_next = sel_shifts ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                if (cnt == AW'(1)) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Command capture and one engine step per SHIFT cycle. In DONE nothing
    // is written, which keeps the response stable while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= '0;
            acc        <= '0;
            id_q       <= '0;
            cnt        <= '0;
            sign_q     <= 1'b0;
            last_grant <= LAST_GRANT_RST;
        end else if (accept) begin
            op_q       <= sel_op;
            acc        <= sel_data;
            id_q       <= grant_idx;
            cnt        <= sel_amt;
            sign_q     <= sel_data[W-1];
            last_grant <= grant_idx;
        end else if (state == S_SHIFT) begin
            acc        <= step_out;
            cnt        <= cnt - AW'(1);
        end
    end

    shift_step #(
        .W (W)
    ) u_step (
        .op       (op_q),
        .data_in  (acc),
        .sign     (sign_q),
        .data_out (step_out)
    );

    assign rsp_valid = (state == S_DONE);
    assign rsp_data  = acc;
    assign rsp_id    = id_q;
    assign busy      = (state != S_IDLE);

endmodule

// File: doc/shift_sched.md
# shift_sched

Round-robin scheduler that shares a single iterative 8-bit shift/rotate engine between `NREQ` requesters. Each requester issues a command (op, data, amount) with a valid/ready handshake. The scheduler grants one command at a time and steps the engine one bit position per cycle. It returns the result with the requester id over a valid/ready response channel. It sits between the word-level shift/rotate datapath and the clients that previously drove it directly.

## Interface
- `W`, 8, data width; must be a power of 2.
- `NREQ`, 2, number of requesters; 2..8.
- `AW`, `$clog2(W)`, shift-amount width; derived, not overridable.
- `clk` in 1 — clock.
- `rst` in 1 — reset, asynchronous, active-high.
- `req_valid` in NREQ — per-requester command valid.
- `req_ready` out NREQ — per-requester accept; at most one bit high.
- `req_op` in 3*NREQ — op code; requester i uses bits [3i+2:3i].
- `req_data` in W*NREQ — operand; requester i uses bits [Wi+W-1:Wi].
- `req_amt` in AW*NREQ — shift amount 0..W-1.
- `rsp_valid` out 1 — result valid.
- `rsp_ready` in 1 — consumer accepts the result.
- `rsp_data` out W — result.
- `rsp_id` out $clog2(NREQ) — index of the requester that issued the command.
- `busy` out 1 — high in SHIFT or DONE.

## Operation
- Op codes:
  - 0 ROTR, 1 ROTL, 2 SHL, 3 SHR (zero fill), 4 ASR (sign fill).
  - 5–7 PASS: result = data, treated as amt = 0.
- FSM states:
  - IDLE:
    - If any `req_valid` is high, grant the first valid requester searching upward (with wrap) from `last_grant+1`.
    - `req_ready[g]` is high combinationally in this cycle only.
    - Capture op, data, amt and id; set `last_grant <= g`.
    - If amt == 0 or op is PASS, go to DONE; otherwise go to SHIFT with `cnt <= amt`.
  - SHIFT:
    - Each cycle, the accumulator takes one 1-bit step of the op and `cnt` decrements.
    - When `cnt == 1`, go to DONE after the step.
  - DONE:
    - `rsp_valid` = 1; `rsp_data`/`rsp_id` are held stable.
    - On `rsp_valid && rsp_ready`, go to IDLE.
- `req_ready` is all-zero outside IDLE. No command is accepted in the same cycle a response completes.
- Arithmetic is modulo W; bits shifted out are discarded except for rotates. ASR replicates the MSB captured at grant.
- `req_valid` deasserted without a handshake is legal; requesters are never starved, because each waits at most NREQ-1 grants.

## Timing
- Reset values:
  - state = IDLE; `rsp_valid` = 0, `rsp_data` = 0, `rsp_id` = 0, `busy` = 0, `req_ready` = 0.
  - `last_grant` = NREQ-1, so requester 0 has first priority.
- Latency: accept at cycle T, `rsp_valid` rises at T+1+amt (T+1 for amt 0/PASS).
- Back-to-back throughput: one command per amt+2 cycles with `rsp_ready` held high.
- Reset mid-operation: an in-flight command is dropped, with no response; the next grant goes to requester 0.
- `rsp_ready` low in DONE: the FSM stalls indefinitely with outputs stable.

## Structure
- Shared package `shift_sched_pkg`:
  - op enum (`OP_ROTR`..`OP_PASS`)
  - FSM state enum (`S_IDLE`, `S_SHIFT`, `S_DONE`)
  - constant `RST_GRANT`.
- Sub-module `shift_step`: combinational 1-bit step of a W-bit word for a given op. It is instantiated once in `shift_sched`.
- The round-robin grant logic stays inline.

## Test plan
- Requester 0 sends ROTR 0x81 amt 3 → `rsp_data` 0x30, `rsp_id` 0, `rsp_valid` 4 cycles after the accept.
- Requester 1 sends ASR 0x90 amt 2 → 0xE4; then SHL 0xFF amt 7 → 0x80; then ROTL 0x81 amt 1 → 0x03.
- Both requesters hold valid continuously with amt 0 and `rsp_ready` = 1:
  - grants alternate 0,1,0,1;
  - one accept every 2 cycles;
  - `req_ready` is never high for both at once.
- Op 6 (PASS) with data 0x5A amt 5 → 0x5A after 1 cycle. `rsp_ready` low for 5 cycles → `rsp_valid`, `rsp_data` and `rsp_id` stay constant and no `req_ready` is asserted.
- Assert `rst` during SHIFT of a ROTR amt 7 command:
  - all outputs return to reset values the same cycle;
  - no response is produced;
  - with both requesters valid after reset, requester 0 is granted first.
